// File: rtl/regfile_mp.sv
// Multi-port integer register file: two write ports, NREAD combinational read ports,
// optional write-to-read forwarding and a per-register pending scoreboard for RAW detection.
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int NREAD    = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREG)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wen0,
    input  logic [AW-1:0]         regW0_sel,
    input  logic [XLEN-1:0]       regW0_i,
    input  logic                  wen1,
    input  logic [AW-1:0]         regW1_sel,
    input  logic [XLEN-1:0]       regW1_i,
    input  logic [NREAD*AW-1:0]   rd_sel,
    output logic [NREAD*XLEN-1:0] rd_o,
    output logic [NREAD-1:0]      rd_busy,
    input  logic                  claim,
    input  logic [AW-1:0]         claim_sel,
    output logic [NREG-1:0]       busy_o
);

    logic [XLEN-1:0] r_mem [NREG];
    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_wr0, w_wr1, w_clm;

    // One-hot write/claim masks; register 0 masked out when hardwired to zero
    always_comb begin
        w_wr0 = '0;
        w_wr1 = '0;
        w_clm = '0;
        if (wen0)  w_wr0[regW0_sel] = 1'b1;
        if (wen1)  w_wr1[regW1_sel] = 1'b1;
        if (claim) w_clm[claim_sel] = 1'b1;
        if (ZERO_REG != 0) begin
            w_wr0[0] = 1'b0;
            w_wr1[0] = 1'b0;
            w_clm[0] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) r_mem[r] <= '0;
            r_busy <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (w_wr1[r])      r_mem[r] <= regW1_i;
                else if (w_wr0[r]) r_mem[r] <= regW0_i;
            end
            // A new claim supersedes a completing write to the same register
            r_busy <= (r_busy & ~(w_wr0 | w_wr1)) | w_clm;
        end
    end

    assign busy_o = r_busy;

    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [AW-1:0] w_sel;
        logic          w_zero, w_hit0, w_hit1;

        assign w_sel  = rd_sel[i*AW +: AW];
        assign w_zero = (ZERO_REG != 0) && (w_sel == '0);
        assign w_hit1 = (BYPASS != 0) && wen1 && (regW1_sel == w_sel);
        assign w_hit0 = (BYPASS != 0) && wen0 && (regW0_sel == w_sel);

        assign rd_o[i*XLEN +: XLEN] = (rst || w_zero) ? '0      :
                                      w_hit1          ? regW1_i :
                                      w_hit0          ? regW0_i :
                                                        r_mem[w_sel];
        assign rd_busy[i] = !(rst || w_zero || w_hit0 || w_hit1) && r_busy[w_sel];
    end

endmodule
